// File: rtl/l2_bank_init_adapter.sv
// TCDM-to-SRAM bank adapter that fills the bank with INIT_VALUE after reset or on request,
// blocking TCDM traffic while the fill sweep runs.
module l2_bank_init_adapter #(
    parameter int unsigned ADDR_WIDTH    = 14,
    parameter int unsigned BANK_WORDS    = 16384,
    parameter logic [31:0] INIT_VALUE    = 32'h0000_0000,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_start_i,
    output logic                  init_busy_o,
    output logic                  init_done_o,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  r_valid_o,
    output logic                  r_err_o,
    output logic [31:0]           r_rdata_o,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

    localparam int unsigned           CMP_W      = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BANK_WORDS - 1);
    localparam logic [CMP_W-1:0]      BANK_LIMIT = CMP_W'(BANK_WORDS);
    localparam logic [31:0]           ERR_DATA   = 32'hDEAD_BEEF;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  boot_q, boot_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rerr_q, rerr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [31:0]           hold_q, hold_d;
    logic                  in_range;

    // State and response registers; boot_q remembers that reset was just released
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            boot_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            boot_q    <= boot_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            rd_pend_q <= rd_pend_d;
            hold_q    <= hold_d;
        end
    end

    // Next state, grant and bank port steering
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = done_q;
        boot_d      = 1'b0;
        rvalid_d    = 1'b0;
        rerr_d      = 1'b0;
        rd_pend_d   = 1'b0;
        hold_d      = hold_q;
        gnt_o       = 1'b0;
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_be_o    = 4'h0;
        mem_add_o   = '0;
        mem_wdata_o = 32'h0;
        in_range    = ({1'b0, add_i} < BANK_LIMIT);

        if (rd_pend_q) begin
            hold_d = mem_rdata_i;
        end

        case (state_q)
            ST_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    rvalid_d  = 1'b1;
                    rerr_d    = ~in_range;
                    rd_pend_d = in_range & wen_i;
                    if (in_range) begin
                        mem_csn_o   = 1'b0;
                        mem_wen_o   = wen_i;
                        mem_be_o    = be_i;
                        mem_add_o   = add_i;
                        mem_wdata_o = wdata_i;
                    end
                end
                if (init_start_i || (boot_q && INIT_ON_RESET)) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            ST_INIT: begin
                mem_csn_o   = 1'b0;
                mem_wen_o   = 1'b0;
                mem_be_o    = 4'hF;
                mem_add_o   = cnt_q;
                mem_wdata_o = INIT_VALUE;
                // Counter parks on the last address so a full 2^ADDR_WIDTH bank never wraps
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst_i) begin
            gnt_o       = 1'b0;
            mem_csn_o   = 1'b1;
            mem_wen_o   = 1'b1;
            mem_be_o    = 4'h0;
            mem_add_o   = '0;
            mem_wdata_o = 32'h0;
        end
    end

    // In-range reads pass bank data straight through; otherwise show the held word
    always_comb begin
        if (rd_pend_q) begin
            r_rdata_o = mem_rdata_i;
        end else if (rvalid_q && rerr_q) begin
            r_rdata_o = ERR_DATA;
        end else begin
            r_rdata_o = hold_q;
        end
    end

    assign init_busy_o = (state_q == ST_INIT) && !rst_i;
    assign init_done_o = done_q;
    assign r_valid_o   = rvalid_q;
    assign r_err_o     = rerr_q;

endmodule
